// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and state encoding
//
// Purpose: constants and the slave FSM state type, shared by the SPI slave
// and master cores.
// Ports: none (package).
package spi_pkg;

  // Bits in one SPI word, MSB first on the wire.
  localparam int SPI_BITS_PER_BYTE = 8;

  // Flops in each asynchronous-input synchronizer chain.
  localparam int SPI_SYNC_STAGES = 2;

  // Bit counter sizing derived from the word length.
  localparam int SPI_CNT_W = $clog2(SPI_BITS_PER_BYTE);
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_LAST = SPI_CNT_W'(SPI_BITS_PER_BYTE - 1);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SELECTED = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_2ff.sv
// rtl/spi_sync_2ff.sv - multi-flop synchronizer for one asynchronous input
//
// Purpose: brings one asynchronous pin into the clk domain through
// SPI_SYNC_STAGES flops. The reset value is an input so that a clock pin can
// be parked at its configured idle level.
// Ports:
//   clk     - system clock
//   rst_l   - synchronous active-low reset
//   rst_val - value loaded into every stage during reset
//   d       - asynchronous input
//   q       - synchronized output
module spi_sync_2ff (
  input  logic clk,
  input  logic rst_l,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  import spi_pkg::*;

  logic [SPI_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ff <= {SPI_SYNC_STAGES{rst_val}};
    end else begin
      ff <= {ff[SPI_SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave, all four modes, oversampled by i_Clk
//
// Purpose: SPI slave that oversamples SCLK/CS_n/MOSI with the system clock
// (i_Clk at least 8x SPI_CLK). It has a one-byte TX holding register and
// reports each received byte with a one-cycle strobe.
// Optional feature: define SPI_SLAVE_UNDERRUN_EN to add the TX_Underrun output.
// Ports:
//   i_Clk, i_Rst_L        - system clock, synchronous active-low reset
//   CPOL, CPHA            - SPI mode; static while selected
//   SPI_CLK, SPI_CS_n,
//   SPI_MOSI              - asynchronous pins from the master
//   SPI_MISO, SPI_MISO_En - serial data to the master and its enable
//   TX_Byte, TX_DataValid,
//   TX_Ready              - holding-register write port (Ready = empty)
//   RX_Byte, RX_DataValid - last received byte and its one-cycle strobe
//   Busy                  - synchronized chip select is active
//   TX_Underrun           - sticky: a load found the holding register empty
module spi_slave_core (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       SPI_CLK,
  input  logic       SPI_CS_n,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_En,
  input  logic [7:0] TX_Byte,
  input  logic       TX_DataValid,
  output logic       TX_Ready,
  output logic [7:0] RX_Byte,
  output logic       RX_DataValid,
  output logic       Busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic       TX_Underrun
`endif
);
  import spi_pkg::*;

  // Synchronized pins and their one-cycle-delayed copies for edge detection.
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;

  spi_sync_2ff u_sync_sclk (.clk(i_Clk), .rst_l(i_Rst_L), .rst_val(CPOL), .d(SPI_CLK), .q(sclk_s));
  spi_sync_2ff u_sync_cs   (.clk(i_Clk), .rst_l(i_Rst_L), .rst_val(1'b1), .d(SPI_CS_n), .q(cs_s));
  spi_sync_2ff u_sync_mosi (.clk(i_Clk), .rst_l(i_Rst_L), .rst_val(1'b0), .d(SPI_MOSI), .q(mosi_s));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  logic sclk_chg, lead_edge, trail_edge, cs_fall, cs_rise;
  assign sclk_chg   = sclk_s ^ sclk_d;
  assign lead_edge  = sclk_chg & (sclk_d == CPOL);
  assign trail_edge = sclk_chg & (sclk_s == CPOL);
  assign cs_fall    = cs_d & ~cs_s;
  assign cs_rise    = ~cs_d & cs_s;

  // After reset the synchronizers hold reset values, not the pin. A chip
  // select still held low across reset would then look like a fresh falling
  // edge. The slave arms only after it has seen a real, settled high on CS_n.
  logic [SPI_SYNC_STAGES-1:0] sync_ok;
  logic                       cs_armed;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_ok  <= '0;
      cs_armed <= 1'b0;
    end else begin
      sync_ok <= {sync_ok[SPI_SYNC_STAGES-2:0], 1'b1};
      if (sync_ok[SPI_SYNC_STAGES-1] && cs_s) begin
        cs_armed <= 1'b1;
      end
    end
  end

  spi_state_t state, next_state;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (cs_fall && cs_armed) next_state = ST_SELECTED;
      ST_SELECTED: if (cs_rise) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // SCLK edges count only while selected and not in the cycle CS_n releases.
  logic                 active, sample_ev, shift_ev, enter, byte_end, load;
  logic [SPI_CNT_W-1:0] bit_cnt;

  assign active    = (state == ST_SELECTED) & ~cs_rise;
  assign sample_ev = active & (CPHA ? trail_edge : lead_edge);
  // In CPHA=0 the trailing edge right after a word boundary (count back at 0)
  // must not shift: the freshly loaded bit 7 is still due on the next lead.
  assign shift_ev  = active & (CPHA ? lead_edge : (trail_edge & (bit_cnt != '0)));
  assign enter     = (state == ST_IDLE) & (next_state == ST_SELECTED);
  assign byte_end  = sample_ev & (bit_cnt == SPI_CNT_LAST);
  assign load      = enter | byte_end;

  // TX holding register: one byte, filled by the host, drained by loads.
  logic       hold_full;
  logic [7:0] hold_data;
  logic       wr_acc;

  assign wr_acc   = TX_DataValid & ~hold_full;
  assign TX_Ready = ~hold_full;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else begin
      if (load) begin
        hold_full <= 1'b0;
      end
      // Only possible when empty, so it never collides with a draining load.
      if (wr_acc) begin
        hold_full <= 1'b1;
        hold_data <= TX_Byte;
      end
    end
  end

  // TX shift register. CPHA=0 drives bit 7 directly. CPHA=1 presents each
  // bit through miso_q on the leading edge, ahead of the trailing sample.
  logic [7:0] tx_shift;
  logic       miso_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      tx_shift <= 8'h00;
      miso_q   <= 1'b0;
    end else begin
      if (load) begin
        tx_shift <= hold_full ? hold_data : 8'h00;
      end else if (shift_ev) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (enter) begin
        miso_q <= 1'b0;
      end else if (CPHA && shift_ev) begin
        miso_q <= tx_shift[7];
      end
    end
  end

  assign SPI_MISO    = CPHA ? miso_q : tx_shift[7];
  assign SPI_MISO_En = (state == ST_SELECTED);
  assign Busy        = ~cs_s;

  // RX path. A partial word is dropped by clearing the count whenever the
  // slave is not actively selected.
  logic [SPI_BITS_PER_BYTE-2:0] rx_shift;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      RX_Byte      <= 8'h00;
      RX_DataValid <= 1'b0;
    end else begin
      RX_DataValid <= 1'b0;
      if (!active) begin
        bit_cnt <= '0;
      end else if (sample_ev) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= {rx_shift[SPI_BITS_PER_BYTE-3:0], mosi_s};
        if (bit_cnt == SPI_CNT_LAST) begin
          RX_Byte      <= {rx_shift, mosi_s};
          RX_DataValid <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  // Set wins over clear: a byte that went out as 8'h00 is reported even if a
  // write lands in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      TX_Underrun <= 1'b0;
    end else if (load && !hold_full) begin
      TX_Underrun <= 1'b1;
    end else if (wr_acc) begin
      TX_Underrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - scoreboard bench for spi_slave_core
module tb_spi_slave_core;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       CPOL, CPHA;
  logic       SPI_CLK, SPI_CS_n, SPI_MOSI;
  logic       SPI_MISO, SPI_MISO_En;
  logic [7:0] TX_Byte;
  logic       TX_DataValid;
  logic       TX_Ready;
  logic [7:0] RX_Byte;
  logic       RX_DataValid;
  logic       Busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       TX_Underrun;
`endif

  spi_slave_core dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .CPOL(CPOL), .CPHA(CPHA),
    .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_En(SPI_MISO_En),
    .TX_Byte(TX_Byte), .TX_DataValid(TX_DataValid), .TX_Ready(TX_Ready),
    .RX_Byte(RX_Byte), .RX_DataValid(RX_DataValid), .Busy(Busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .TX_Underrun(TX_Underrun)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] obs_miso[$];

  // Per-transfer stimulus: MOSI byte, TX byte, and whether the TX byte is
  // written in time for that word (otherwise the slave must return 8'h00).
  logic [7:0] tx_mosi[4];
  logic [7:0] tx_data[4];
  bit         tx_wr[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge i_Clk) begin
    if (RX_DataValid) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected act=%02h exp=none", RX_Byte);
      end else begin
        chk("rx_byte", RX_Byte, exp_rx.pop_front());
      end
    end
    if (obs_miso.size() > 0) begin
      if (exp_miso.size() == 0) begin
        total++;
        bad++;
        $display("FAIL miso_unexpected act=%02h exp=none", obs_miso.pop_front());
      end else begin
        chk("miso_byte", obs_miso.pop_front(), exp_miso.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  // Half an SPI bit period (4 i_Clk). Optionally spends its first cycle on a
  // TX write, which the model says always finds the holding register empty.
  task automatic half_wait(input bit do_wr, input logic [7:0] v);
    if (do_wr) begin
      chk("tx_ready_before_wr", TX_Ready, 1);
      TX_Byte      = v;
      TX_DataValid = 1'b1;
      cycles(1);
      TX_DataValid = 1'b0;
      chk("tx_ready_after_wr", TX_Ready, 0);
`ifdef SPI_SLAVE_UNDERRUN_EN
      chk("underrun_cleared_by_wr", TX_Underrun, 0);
`endif
      cycles(3);
    end else begin
      cycles(4);
    end
  endtask

  task automatic transfer(input int nbytes, input int nbits_last, input bit cpol, input bit cpha);
    int         nb;
    bit         wr;
    logic [7:0] got;
    CPOL     = cpol;
    CPHA     = cpha;
    SPI_CLK  = cpol;
    SPI_CS_n = 1'b1;
    cycles(8);
    if (tx_wr[0]) half_wait(1'b1, tx_data[0]);
    SPI_CS_n = 1'b0;
    half_wait(1'b0, 8'h00);
    half_wait(1'b0, 8'h00);
    for (int k = 0; k < nbytes; k++) begin
      nb  = (k == nbytes - 1) ? nbits_last : 8;
      got = 8'h00;
      if (nb == 8) begin
        exp_rx.push_back(tx_mosi[k]);
        exp_miso.push_back(tx_wr[k] ? tx_data[k] : 8'h00);
      end
      for (int b = 7; b >= 8 - nb; b--) begin
        wr = (b == 5) && (k + 1 < nbytes) && tx_wr[k+1];
        if (!cpha) begin
          SPI_MOSI = tx_mosi[k][b];
          half_wait(wr, tx_data[k+1]);
          got     = {got[6:0], SPI_MISO};
          SPI_CLK = ~cpol;
          half_wait(1'b0, 8'h00);
          SPI_CLK = cpol;
        end else begin
          SPI_CLK  = ~cpol;
          SPI_MOSI = tx_mosi[k][b];
          half_wait(wr, tx_data[k+1]);
          got     = {got[6:0], SPI_MISO};
          SPI_CLK = cpol;
          half_wait(1'b0, 8'h00);
        end
      end
      if (nb == 8) obs_miso.push_back(got);
    end
    half_wait(1'b0, 8'h00);
    SPI_CS_n = 1'b1;
    cycles(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, SPI_MISO, 0);
    chk({tag, "_miso_en"}, SPI_MISO_En, 0);
    chk({tag, "_tx_ready"}, TX_Ready, 1);
    chk({tag, "_rx_byte"}, RX_Byte, 8'h00);
    chk({tag, "_rx_dv"}, RX_DataValid, 0);
    chk({tag, "_busy"}, Busy, 0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk({tag, "_underrun"}, TX_Underrun, 0);
`endif
  endtask

  initial begin
    i_Rst_L      = 1'b0;
    CPOL         = 1'b0;
    CPHA         = 1'b0;
    SPI_CLK      = 1'b0;
    SPI_CS_n     = 1'b1;
    SPI_MOSI     = 1'b0;
    TX_Byte      = 8'h00;
    TX_DataValid = 1'b0;
    cycles(4);
    i_Rst_L = 1'b1;
    check_reset_outputs("reset");

    // Empty holding register: the slave returns 8'h00 and flags underrun.
    tx_mosi[0] = 8'h96; tx_wr[0] = 1'b0; tx_data[0] = 8'h00;
    transfer(1, 8, 1'b0, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("underrun_set", TX_Underrun, 1);
`endif

    // Mode 0, TX 8'hA5 preloaded, master sends 8'h3C.
    tx_mosi[0] = 8'h3C; tx_wr[0] = 1'b1; tx_data[0] = 8'hA5;
    transfer(1, 8, 1'b0, 1'b0);

    // Mode 3, two back-to-back words under one chip select.
    tx_mosi[0] = 8'($urandom); tx_wr[0] = 1'b1; tx_data[0] = 8'h81;
    tx_mosi[1] = 8'($urandom); tx_wr[1] = 1'b1; tx_data[1] = 8'h7E;
    transfer(2, 8, 1'b1, 1'b1);

    // Chip select released after 5 bits, then a full 8'hF0 word.
    tx_mosi[0] = 8'($urandom); tx_wr[0] = 1'b1; tx_data[0] = 8'($urandom);
    transfer(1, 5, 1'b0, 1'b0);
    tx_mosi[0] = 8'hF0; tx_wr[0] = 1'b1; tx_data[0] = 8'($urandom);
    transfer(1, 8, 1'b0, 1'b0);

    // One-cycle reset in the middle of a word, chip select kept low.
    CPOL = 1'b0; CPHA = 1'b0; SPI_CLK = 1'b0;
    cycles(8);
    half_wait(1'b1, 8'hC3);
    SPI_CS_n = 1'b0;
    half_wait(1'b0, 8'h00);
    half_wait(1'b0, 8'h00);
    for (int b = 0; b < 4; b++) begin
      SPI_MOSI = b[0];
      half_wait(1'b0, 8'h00);
      SPI_CLK = 1'b1;
      half_wait(1'b0, 8'h00);
      SPI_CLK = 1'b0;
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    @(posedge i_Clk);
    #1;
    check_reset_outputs("midreset");
    i_Rst_L = 1'b1;
    // Still selected on the pin, but no new falling edge: must stay idle.
    for (int b = 0; b < 8; b++) begin
      half_wait(1'b0, 8'h00);
      SPI_CLK = 1'b1;
      half_wait(1'b0, 8'h00);
      SPI_CLK = 1'b0;
    end
    chk("after_reset_miso_en", SPI_MISO_En, 0);
    chk("after_reset_busy", Busy, 1);
    SPI_CS_n = 1'b1;
    cycles(8);
    tx_mosi[0] = 8'h55; tx_wr[0] = 1'b1; tx_data[0] = 8'($urandom);
    transfer(1, 8, 1'b0, 1'b0);

    // Randomized transfers in all modes against the word-level model.
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        tx_mosi[k] = 8'($urandom);
        tx_data[k] = 8'($urandom);
        tx_wr[k]   = ($urandom_range(0, 3) != 0);
      end
      transfer(n, 8, 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 200 && (exp_rx.size() > 0 || obs_miso.size() > 0); i++) begin
      cycles(1);
    end
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have i_Clk  input  1  system clock; all logic on rising edge; i_Clk >= 8x SPI_CLK frequency.
REQ-002 SHALL have i_Rst_L  input  1  reset; synchronous, active-low.
REQ-003 SHALL have CPOL  input  1  SPI clock idle level; static while SPI_CS_n low.
REQ-004 SHALL have CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge; static while SPI_CS_n low.
REQ-005 SHALL have SPI_CLK  input  1  asynchronous serial clock from master.
REQ-006 SHALL have SPI_CS_n  input  1  asynchronous chip select, active-low.
REQ-007 SHALL have SPI_MOSI  input  1  asynchronous serial data from master, MSB first.
REQ-008 SHALL have SPI_MISO  output  1  serial data to master, MSB first.
REQ-009 SHALL have SPI_MISO_En  output  1  MISO output enable; 1 only while selected.
REQ-010 SHALL have TX_Byte  input  8  next byte to return to master.
REQ-011 SHALL have TX_DataValid  input  1  TX_Byte write strobe; accepted when TX_Ready=1.
REQ-012 SHALL have TX_Ready  output  1  TX holding register empty.
REQ-013 SHALL have RX_Byte  output  8  last complete received byte; held until next completion.
REQ-014 SHALL have RX_DataValid  output  1  one-cycle pulse per complete received byte.
REQ-015 SHALL have Busy  output  1  synchronized SPI_CS_n is low.

Function
REQ-016 SHALL pass SPI_CLK, SPI_CS_n, SPI_MOSI through 2-flop synchronizers, then a 1-flop edge detector; internal edge events are single-cycle pulses 3 i_Clk cycles after the pin transition.
REQ-017 SHALL define leading edge as synced SPI_CLK leaving CPOL and trailing edge as returning to CPOL.
REQ-018 SHALL use two states, IDLE and SELECTED: IDLE->SELECTED on synced CS_n falling; SELECTED->IDLE on synced CS_n rising; in IDLE, edges on SPI_CLK are ignored.
REQ-019 SHALL, on entry to SELECTED and after every 8th sample edge, load the shift register from the holding register (holding register becomes empty, TX_Ready=1 next cycle), or load 8'h00 if the holding register is empty.
REQ-020 SHALL drive SPI_MISO = shift register bit 7 from the load cycle when CPHA=0; shift left on each trailing edge.
REQ-021 SHALL, when CPHA=1, update SPI_MISO to the next bit on each leading edge; first leading edge presents bit 7.
REQ-022 SHALL shift synced MOSI into the RX shift register on each sample edge; 3-bit counter wraps 7->0; at count 7, RX_Byte updates and RX_DataValid pulses the following cycle.
REQ-023 SHALL accept a write (TX_DataValid & TX_Ready) into the holding register; write while TX_Ready=0 is ignored; write in the same cycle as a load fills the holding register for the following byte.
REQ-024 SHALL, on CS_n rising mid-byte, discard the partial RX byte (no RX_DataValid), clear the bit counter, drop SPI_MISO_En; the holding register contents are retained.
REQ-025 SHALL support back-to-back bytes under continuous CS_n low with no idle SPI_CLK period.

Reset
REQ-026 SHALL, while i_Rst_L=0 at a clock edge, set state IDLE, SPI_MISO=0, SPI_MISO_En=0, TX_Ready=1, RX_Byte=8'h00, RX_DataValid=0, Busy=0, synchronizers to idle values (CS_n=1, SCLK=CPOL), counters 0, holding register empty.
REQ-027 SHALL, on reset mid-transfer, abandon the byte and require a new CS_n falling edge before responding.

Configuration
REQ-028 SHALL, with SPI_SLAVE_UNDERRUN_EN defined, add output TX_Underrun (1 bit): sticky flag set when a load finds the holding register empty, cleared by reset or by an accepted TX write; without the macro, the port and logic are absent.

Structure
REQ-029 SHALL place SPI_BITS_PER_BYTE (8), SPI_SYNC_STAGES (2), and the state encoding in shared package spi_pkg, also used by SPI_Master_Core.
REQ-030 SHALL instantiate sub-module spi_sync_2ff, one instance per asynchronous input.

Verification
REQ-031 SHALL test mode 0: TX 8'hA5 preloaded, master sends 8'h3C at 1/8 i_Clk -> MISO returns 8'hA5, RX_Byte=8'h3C, one RX_DataValid pulse.
REQ-032 SHALL test mode 3: TX 8'h81 then 8'h7E, two back-to-back bytes under one CS -> MISO returns 8'h81, 8'h7E; two RX pulses.
REQ-033 SHALL test empty holding register: no TX write, 1-byte transfer -> MISO 8'h00; TX_Underrun=1 when the macro is defined.
REQ-034 SHALL test CS_n rising after 5 bits -> no RX_DataValid; next full byte 8'hF0 received correctly.
REQ-035 SHALL test i_Rst_L low for 1 cycle mid-byte -> all outputs at reset values; later transfer of 8'h55 succeeds.
